// File: rtl/iis_rx_fifo_writer.sv
// I2S receiver front-end in the wr_clk domain: synchronises SCK/WS/SD, deserialises
// standard-I2S stereo words MSB-first and pushes left then right samples into the FIFO.
module iis_rx_fifo_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                  rst,
  input  logic                  wr_clk,
  input  logic                  enable,
  input  logic                  i2s_sck,
  input  logic                  i2s_ws,
  input  logic                  i2s_sd,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  overflow,
  output logic                  frame_err,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PUSH,
    WAIT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   sck_dly_q, sck_dly_d;
  logic                   ws_prev_q, ws_prev_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic                   start_pend_q, start_pend_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;

  logic sck_s, ws_s, sd_s;
  logic sck_rise, ws_chg;
  logic set_ovf, set_ferr;

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign ws_s  = ws_sync_q[SYNC_STAGES-1];
  assign sd_s  = sd_sync_q[SYNC_STAGES-1];

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sck_sync_q   <= '0;
      ws_sync_q    <= '0;
      sd_sync_q    <= '0;
      sck_dly_q    <= 1'b0;
      ws_prev_q    <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      din_q        <= '0;
      start_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= sck_sync_d;
      ws_sync_q    <= ws_sync_d;
      sd_sync_q    <= sd_sync_d;
      sck_dly_q    <= sck_dly_d;
      ws_prev_q    <= ws_prev_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      din_q        <= din_d;
      start_pend_q <= start_pend_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], i2s_sck};
    ws_sync_d    = {ws_sync_q[SYNC_STAGES-2:0], i2s_ws};
    sd_sync_d    = {sd_sync_q[SYNC_STAGES-2:0], i2s_sd};
    sck_dly_d    = sck_s;
    sck_rise     = sck_s & ~sck_dly_q;
    ws_chg       = sck_rise & (ws_s != ws_prev_q);
    ws_prev_d    = sck_rise ? ws_s : ws_prev_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    din_d        = din_q;
    start_pend_d = start_pend_q;
    set_ovf      = 1'b0;
    set_ferr     = 1'b0;
    fifo_wr_en   = 1'b0;

    if (!enable) begin
      state_d      = IDLE;
      cnt_d        = '0;
      start_pend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ws_chg && !ws_s) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            // A WS change on the final bit's edge is the normal slot boundary, not an error
            if (ws_chg && (cnt_q != LAST_BIT)) begin
              set_ferr = 1'b1;
              cnt_d    = '0;
            end else begin
              shift_d = {shift_q[DATA_WIDTH-2:0], sd_s};
              cnt_d   = cnt_q + CNT_WIDTH'(1);
              if (cnt_q == LAST_BIT) begin
                state_d      = PUSH;
                start_pend_d = ws_chg;
              end
            end
          end
        end
        PUSH: begin
          if (!fifo_full) begin
            fifo_wr_en = 1'b1;
            din_d      = shift_q;
          end else begin
            set_ovf = 1'b1;
          end
          // The WS edge that completed the word already opened the next slot
          state_d      = start_pend_q ? SHIFT : WAIT;
          cnt_d        = '0;
          start_pend_d = 1'b0;
        end
        WAIT: begin
          if (ws_chg) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    overflow_d  = set_ovf | (overflow_q & ~err_clr);
    frame_err_d = set_ferr | (frame_err_q & ~err_clr);
  end

  assign fifo_din  = fifo_wr_en ? shift_q : din_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_iis_rx_fifo_writer.sv
// Scoreboard bench for iis_rx_fifo_writer: slot-level reference model queues expected
// FIFO words; an independent monitor checks every strobe and the hold value of fifo_din.
module tb_iis_rx_fifo_writer;
  localparam int DW = 16;

  logic          rst = 1'b0;
  logic          wr_clk = 1'b0;
  logic          enable = 1'b1;
  logic          i2s_sck = 1'b0;
  logic          i2s_ws = 1'b0;
  logic          i2s_sd = 1'b0;
  logic          fifo_full = 1'b0;
  logic          err_clr = 1'b0;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic          overflow;
  logic          frame_err;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_exp = '0;
  logic          prev_wr = 1'b0;
  bit            mon_on = 1'b0;

  // slot-level model state
  bit            en_m = 1'b1;
  bit            m_cap = 1'b0;
  bit            p_active = 1'b0;
  bit            p_ws = 1'b0;
  bit            p_full = 1'b0;
  int unsigned   p_len = 0;
  logic [31:0]   p_val = '0;
  bit            m_ovf = 1'b0;
  bit            m_ferr = 1'b0;
  logic          prev_d = 1'b0;

  always #5 wr_clk = ~wr_clk;

  iis_rx_fifo_writer #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(2),
    .CNT_WIDTH  (6)
  ) dut (
    .rst       (rst),
    .wr_clk    (wr_clk),
    .enable    (enable),
    .i2s_sck   (i2s_sck),
    .i2s_ws    (i2s_ws),
    .i2s_sd    (i2s_sd),
    .fifo_full (fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_din  (fifo_din),
    .overflow  (overflow),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge wr_clk) begin
    logic [DW-1:0] e;
    if (mon_on && !rst) begin
      if (fifo_wr_en === 1'b1) begin
        chk("strobe_single_cycle", {31'b0, prev_wr}, 32'd0);
        chk("no_push_when_full", {31'b0, fifo_full}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_push: got %h want none at %0t", fifo_din, $time);
        end else begin
          e = exp_q.pop_front();
          chk("push_data", {16'b0, fifo_din}, {16'b0, e});
          last_exp = e;
        end
      end else begin
        chk("din_hold", {16'b0, fifo_din}, {16'b0, last_exp});
      end
      prev_wr = fifo_wr_en;
    end
  end

  // one SCK period = 8 wr_clk; SD carries the previous bit (one-bit I2S delay)
  task automatic sck_cycle(input logic ws, input logic d, input logic clr);
    i2s_ws  = ws;
    i2s_sd  = prev_d;
    prev_d  = d;
    err_clr = clr;
    @(posedge wr_clk); #1 err_clr = 1'b0;
    repeat (3) @(posedge wr_clk);
    #1 i2s_sck = 1'b1;
    repeat (4) @(posedge wr_clk);
    #1 i2s_sck = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("rst_din", {16'b0, fifo_din}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    @(posedge wr_clk); #1 rst = 1'b0;
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    m_cap = 1'b0;
    last_exp = '0;
    prev_wr = 1'b0;
  endtask

  // evt: 0 none, 1 enable drop, 2 enable raise, 3 reset pulse (applied at period evt_at)
  task automatic play_slot(input logic ws, input int unsigned len, input logic [31:0] val,
                           input bit full, input bit clr, input int unsigned evt,
                           input int unsigned evt_at);
    bit act;
    int unsigned fwin;
    bit fval;
    fwin = 0;
    fval = 1'b0;
    if (p_active) begin
      if (p_len == DW) begin
        fwin = 3;
        fval = p_full;
        if (p_full) m_ovf = 1'b1;
        else exp_q.push_back(p_val[31 -: DW]);
      end else if (p_len < DW) begin
        m_ferr = 1'b1;
      end
    end
    if (!m_cap && en_m && ws == 1'b0 && p_ws == 1'b1) m_cap = 1'b1;
    act = m_cap && en_m;
    for (int unsigned p = 0; p < len; p++) begin
      if (p == 3) begin
        chk("overflow_flag", {31'b0, overflow}, {31'b0, m_ovf});
        chk("frame_err_flag", {31'b0, frame_err}, {31'b0, m_ferr});
      end
      if (p == 4 && clr) begin
        m_ovf = 1'b0;
        m_ferr = 1'b0;
      end
      if (p == DW && act && len > DW) begin
        fwin = 3;
        fval = full;
        if (full) m_ovf = 1'b1;
        else exp_q.push_back(val[31 -: DW]);
      end
      if (evt != 0 && p == evt_at) begin
        case (evt)
          1: begin enable = 1'b0; en_m = 1'b0; m_cap = 1'b0; act = 1'b0; end
          2: begin enable = 1'b1; en_m = 1'b1; end
          default: begin pulse_reset(); act = 1'b0; end
        endcase
      end
      if (fwin > 0) begin
        fifo_full = fval;
        fwin--;
      end else begin
        fifo_full = 1'($urandom_range(0, 1));
      end
      sck_cycle(ws, val[31-p], (p == 4) && clr);
    end
    p_active = act;
    p_len = len;
    p_full = full;
    p_val = val;
    p_ws = ws;
  endtask

  initial begin
    int unsigned len, evt, evt_at;
    logic nws;
    #3;
    @(posedge wr_clk); #1;
    pulse_reset();
    mon_on = 1'b1;
    repeat (4) @(posedge wr_clk); #1;

    // 16-bit slots after a right-slot prelude
    play_slot(1'b1, 16, $urandom, 1'b0, 1'b0, 0, 0);
    play_slot(1'b0, 16, 32'hA5A5_0000, 1'b0, 1'b0, 0, 0);
    play_slot(1'b1, 16, 32'h1234_0000, 1'b0, 1'b0, 0, 0);
    // 32-bit slots: LSBs truncated
    play_slot(1'b0, 32, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 0);
    play_slot(1'b1, 32, 32'h0F0F_1234, 1'b0, 1'b0, 0, 0);
    // FIFO full on the left push only
    play_slot(1'b0, 16, 32'hA5A5_0000, 1'b1, 1'b0, 0, 0);
    play_slot(1'b1, 16, 32'h1234_0000, 1'b0, 1'b0, 0, 0);
    // short left slot, then clear
    play_slot(1'b0, 8, $urandom, 1'b0, 1'b0, 0, 0);
    play_slot(1'b1, 16, 32'h5A5A_0000, 1'b0, 1'b0, 0, 0);
    play_slot(1'b0, 16, 32'h0001_0000, 1'b0, 1'b1, 0, 0);
    // enable dropped, then raised mid-right slot
    play_slot(1'b1, 16, $urandom, 1'b0, 1'b0, 1, 6);
    play_slot(1'b0, 16, $urandom, 1'b0, 1'b0, 0, 0);
    play_slot(1'b1, 16, 32'hBAD0_0000, 1'b0, 1'b0, 2, 8);
    play_slot(1'b0, 16, 32'hC0DE_0000, 1'b0, 1'b0, 0, 0);
    play_slot(1'b1, 16, 32'h7777_0000, 1'b0, 1'b0, 0, 0);
    // reset at bit 5 of a left word
    play_slot(1'b0, 16, 32'h9999_0000, 1'b0, 1'b0, 3, 6);
    play_slot(1'b1, 16, 32'h8888_0000, 1'b0, 1'b0, 0, 0);
    play_slot(1'b0, 16, 32'h4321_0000, 1'b0, 1'b0, 0, 0);
    play_slot(1'b1, 24, $urandom, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 120; i++) begin
      nws = ~p_ws;
      if ($urandom_range(0, 9) == 0) len = 8;
      else begin
        case ($urandom_range(0, 6))
          0, 1: len = 16;
          2: len = 17;
          3: len = 20;
          4: len = 24;
          5: len = 31;
          default: len = 32;
        endcase
      end
      evt = 0;
      if (!en_m && $urandom_range(0, 2) == 0) evt = 2;
      else if (en_m && $urandom_range(0, 19) == 0) evt = 1;
      else if ($urandom_range(0, 29) == 0) evt = 3;
      evt_at = (len > 16) ? $urandom_range(5, 15) : $urandom_range(5, len - 1);
      play_slot(nws, len, $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                evt, evt_at);
    end

    play_slot(~p_ws, 16, $urandom, 1'b0, 1'b0, 0, 0);
    play_slot(~p_ws, 16, $urandom, 1'b0, 1'b0, 0, 0);
    repeat (16) @(posedge wr_clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1);
  end
endmodule
